min_max_ctrl: RTL

MIN_MAX_CTRL -- requirements
Module: min_max_ctrl

---
 rtl/min_max_ctrl_if.sv | 27 ++
 rtl/min_max_ctrl.sv | 106 ++++++++++
 2 files changed

// File: rtl/min_max_ctrl_if.sv
// min_max_ctrl_if: config handshake, self-test control and display operands of min_max_ctrl
//   start_i, cfg_valid_i, cfg_min_i/cfg_max_i/cfg_val_i  towards controller
//   cfg_ready_o, busy_o, done_o, err_o, com_o, min_o/max_o/val_o, osc_o  from controller
interface min_max_ctrl_if #(parameter int VALSIZE = 4);
    logic               start_i;
    logic               cfg_valid_i;
    logic               cfg_ready_o;
    logic [VALSIZE-1:0] cfg_min_i;
    logic [VALSIZE-1:0] cfg_max_i;
    logic [VALSIZE-1:0] cfg_val_i;
    logic               busy_o;
    logic               done_o;
    logic               err_o;
    logic [1:0]         com_o;
    logic [VALSIZE-1:0] min_o;
    logic [VALSIZE-1:0] max_o;
    logic [VALSIZE-1:0] val_o;
    logic               osc_o;
    modport master (
        output start_i, cfg_valid_i, cfg_min_i, cfg_max_i, cfg_val_i,
        input  cfg_ready_o, busy_o, done_o, err_o, com_o, min_o, max_o, val_o, osc_o
    );
    modport slave (
        input  start_i, cfg_valid_i, cfg_min_i, cfg_max_i, cfg_val_i,
        output cfg_ready_o, busy_o, done_o, err_o, com_o, min_o, max_o, val_o, osc_o
    );
endinterface

// File: rtl/min_max_ctrl.sv
// min_max_ctrl: holds the display min/max/value configuration and runs the all-off/all-on/sweep self-test
//   clk_i  system clock, rst_i  async active-high reset
//   bus    min_max_ctrl_if slave: config handshake in, mode/operands/status/oscillation out
module min_max_ctrl #(
    parameter int VALSIZE     = 4,
    parameter int OSC_DIV     = 4,
    parameter int STEP_CYCLES = 2
) (
    input logic           clk_i,
    input logic           rst_i,
    min_max_ctrl_if.slave bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ALL_OFF = 2'd1;
    localparam logic [1:0] ALL_ON  = 2'd2;
    localparam logic [1:0] SWEEP   = 2'd3;
    localparam int SW = $clog2(STEP_CYCLES + 1);
    localparam int OW = $clog2(OSC_DIV + 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
    localparam logic [OW-1:0] OSC_LAST  = OW'(OSC_DIV - 1);

    logic [1:0]         state_q, state_d;
    logic [SW-1:0]      step_q, step_d;
    logic [VALSIZE-1:0] sweep_q, sweep_d;
    logic [VALSIZE-1:0] min_q, min_d, max_q, max_d, cfg_val_q, cfg_val_d;
    logic [VALSIZE-1:0] val_q, val_d;
    logic [1:0]         com_q, com_d;
    logic [OW-1:0]      osc_cnt_q;
    logic               osc_q, busy_q, done_q, err_q;
    logic               ready, in_range, accept, last_step, last_val;

    assign ready     = state_q == IDLE;
    assign in_range  = bus.cfg_min_i <= bus.cfg_val_i && bus.cfg_val_i <= bus.cfg_max_i;
    assign accept    = ready && bus.cfg_valid_i && in_range;
    assign last_step = step_q == STEP_LAST;
    assign last_val  = &sweep_q;

    always_comb begin
        state_d = state_q;
        step_d  = last_step ? '0 : step_q + SW'(1);
        sweep_d = sweep_q;
        case (state_q)
            IDLE: begin
                state_d = bus.start_i ? ALL_OFF : IDLE;
                step_d  = '0;
                sweep_d = '0;
            end
            ALL_OFF: state_d = last_step ? ALL_ON : ALL_OFF;
            ALL_ON:  state_d = last_step ? SWEEP : ALL_ON;
            default: begin
                // last value held for its full step ends the test; counter is parked at 0, never wraps
                state_d = (last_step && last_val) ? IDLE : SWEEP;
                sweep_d = !last_step ? sweep_q : last_val ? '0 : sweep_q + VALSIZE'(1);
            end
        endcase
    end

    // outputs are registered from next-state values so they line up with the state they describe
    assign min_d     = accept ? bus.cfg_min_i : min_q;
    assign max_d     = accept ? bus.cfg_max_i : max_q;
    assign cfg_val_d = accept ? bus.cfg_val_i : cfg_val_q;
    assign val_d     = state_d == SWEEP ? sweep_d : cfg_val_d;
    assign com_d     = state_d == ALL_OFF ? 2'b10 : state_d == ALL_ON ? 2'b11 : state_d == SWEEP ? 2'b01 : 2'b00;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            step_q    <= '0;
            sweep_q   <= '0;
            min_q     <= '0;
            max_q     <= '1;
            cfg_val_q <= '0;
            val_q     <= '0;
            com_q     <= 2'b00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            osc_cnt_q <= '0;
            osc_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            sweep_q   <= sweep_d;
            min_q     <= min_d;
            max_q     <= max_d;
            cfg_val_q <= cfg_val_d;
            val_q     <= val_d;
            com_q     <= com_d;
            busy_q    <= state_d != IDLE;
            done_q    <= state_q == SWEEP && state_d == IDLE;
            err_q     <= ready && bus.cfg_valid_i && !in_range;
            osc_cnt_q <= osc_cnt_q == OSC_LAST ? '0 : osc_cnt_q + OW'(1);
            osc_q     <= osc_q ^ (osc_cnt_q == OSC_LAST);
        end
    end

    assign bus.cfg_ready_o = ready;
    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.err_o       = err_q;
    assign bus.com_o       = com_q;
    assign bus.min_o       = min_q;
    assign bus.max_o       = max_q;
    assign bus.val_o       = val_q;
    assign bus.osc_o       = osc_q;
endmodule
